// File: rtl/aes_key_expand_ctrl.sv
// Sequential AES-128/192/256 key expansion: one round-key word per clock into a 64x32 register file.
// Optional nr output port enabled by defining AES_KEY_EXPAND_NR_OUT_EN.
module aes_key_expand_ctrl #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        key_len,
  input  logic [255:0]      key_in,
  input  logic [DATA_W-1:0] sub_out,
  output logic [DATA_W-1:0] sub_in,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done
`ifdef AES_KEY_EXPAND_NR_OUT_EN
  ,
  output logic [3:0]        nr
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, EXPAND, FIN} state_e;

  state_e              state_q, state_d;
  logic [255:0]        key_q, key_d;
  logic [DATA_W-1:0]   win_q [8];
  logic [DATA_W-1:0]   win_d [8];
  logic [ADDR_W-1:0]   i_q, i_d, last_q, last_d;
  logic [2:0]          j_q, j_d, nkm1_q, nkm1_d;
  logic [7:0]          rcon_q, rcon_d;
  logic                wr_en_q, wr_en_d, busy_q, busy_d, done_q, done_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [DATA_W-1:0]   temp, wnew;
  logic                emit;
  logic [2:0]          nkm1_dec;
  logic [ADDR_W-1:0]   last_dec;

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;
  assign done    = done_q;

  always_comb begin
    case (key_len)
      2'd1:    begin nkm1_dec = 3'd5; last_dec = ADDR_W'(51); end
      2'd2:    begin nkm1_dec = 3'd7; last_dec = ADDR_W'(59); end
      default: begin nkm1_dec = 3'd3; last_dec = ADDR_W'(43); end
    endcase
  end

  // Word 0 is emitted straight from key_in on the start edge so it lands in cycle 1;
  // the latched key is then shifted left one word per LOAD cycle.
  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    win_d     = win_q;
    i_d       = i_q;
    j_d       = j_q;
    last_d    = last_q;
    nkm1_d    = nkm1_q;
    rcon_d    = rcon_q;
    wr_en_d   = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    sub_in    = '0;
    temp      = win_q[0];
    wnew      = '0;
    emit      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          nkm1_d    = nkm1_dec;
          last_d    = last_dec;
          key_d     = key_in << 32;
          wnew      = key_in[255:224];
          emit      = 1'b1;
          wr_addr_d = '0;
          i_d       = ADDR_W'(1);
          j_d       = 3'd1;
          rcon_d    = 8'h01;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        wnew      = key_q[255:224];
        key_d     = key_q << 32;
        emit      = 1'b1;
        wr_addr_d = i_q;
        i_d       = i_q + ADDR_W'(1);
        j_d       = (j_q == nkm1_q) ? 3'd0 : j_q + 3'd1;
        if (j_q == nkm1_q) state_d = EXPAND;
      end
      EXPAND: begin
        if (j_q == 3'd0) begin
          sub_in = {win_q[0][23:0], win_q[0][31:24]};
          temp   = sub_out ^ {rcon_q, 24'h0};
          rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1B : 8'h00);
        end else if (nkm1_q == 3'd7 && j_q == 3'd4) begin
          sub_in = win_q[0];
          temp   = sub_out;
        end else begin
          sub_in = win_q[0];
        end
        // win_q[Nk-1] holds w[i-Nk]
        wnew      = win_q[nkm1_q] ^ temp;
        emit      = 1'b1;
        wr_addr_d = i_q;
        i_d       = i_q + ADDR_W'(1);
        j_d       = (j_q == nkm1_q) ? 3'd0 : j_q + 3'd1;
        if (i_q == last_q) state_d = FIN;
      end
      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
    endcase

    if (emit) begin
      win_d[0] = wnew;
      for (int unsigned k = 1; k < 8; k++) win_d[k] = win_q[k-1];
      wr_en_d   = 1'b1;
      busy_d    = 1'b1;
      wr_data_d = wnew;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      key_q     <= '0;
      for (int unsigned k = 0; k < 8; k++) win_q[k] <= '0;
      i_q       <= '0;
      j_q       <= '0;
      last_q    <= '0;
      nkm1_q    <= '0;
      rcon_q    <= 8'h01;
      wr_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      key_q     <= key_d;
      win_q     <= win_d;
      i_q       <= i_d;
      j_q       <= j_d;
      last_q    <= last_d;
      nkm1_q    <= nkm1_d;
      rcon_q    <= rcon_d;
      wr_en_q   <= wr_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

`ifdef AES_KEY_EXPAND_NR_OUT_EN
  logic [3:0] nr_q;
  assign nr = nr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      nr_q <= '0;
    end else if (state_q == IDLE && start) begin
      nr_q <= (key_len == 2'd2) ? 4'd14 : (key_len == 2'd1) ? 4'd12 : 4'd10;
    end
  end
`endif

endmodule

// File: tb/tb_aes_key_expand_ctrl.sv
// Directed bench for aes_key_expand_ctrl: behavioural S-box drives sub_out, reference expansion gives expected words.
module tb_aes_key_expand_ctrl;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [1:0]   key_len;
  logic [255:0] key_in;
  logic [31:0]  sub_out, sub_in, wr_data;
  logic         wr_en, busy, done;
  logic [5:0]   wr_addr;
`ifdef AES_KEY_EXPAND_NR_OUT_EN
  logic [3:0]   nr;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_w [60];
  logic [31:0] got_w [64];

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0123456789abcdeffedcba9876543210};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  aes_key_expand_ctrl #(.ADDR_W(6), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .key_len(key_len), .key_in(key_in),
    .sub_out(sub_out), .sub_in(sub_in), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done)
`ifdef AES_KEY_EXPAND_NR_OUT_EN
    , .nr(nr)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box from the GF(2^8) inverse (a^254) and the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] v;
    v = 8'h00;
    if (a != 8'h00) begin
      v = 8'h01;
      for (int k = 0; k < 254; k++) v = gmul(v, a);
    end
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  always_comb sub_out = subword(sub_in);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic build_model(input logic [255:0] key, input int nk, input int nw);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < nw; i++) begin
      if (i < nk) begin
        exp_w[i] = key[255 - 32*i -: 32];
      end else begin
        t = exp_w[i-1];
        if (i % nk == 0) begin
          t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = xt(rc);
        end else if (nk == 8 && i % nk == 4) begin
          t = subword(t);
        end
        exp_w[i] = exp_w[i-nk] ^ t;
      end
    end
  endtask

  task automatic run(input logic [1:0] kl, input logic [255:0] key, input int nk, input int nw,
                     input int rst_at, input bit repulse);
    int n_done;
    n_done = 0;
    build_model(key, nk, nw);
    #1;
    key_len = kl;
    key_in  = key;
    start   = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= nw + 4; c++) begin
      #1;
      if (done) n_done++;
      if (rst_at > 0 && c > rst_at) begin
        check("rst_out", {wr_en, busy, done, wr_addr, wr_data}, '0);
      end else if (c <= nw) begin
        check("ctrl", {wr_en, busy, done, wr_addr}, {3'b110, 6'(c-1)});
        check("data", wr_data, exp_w[c-1]);
        got_w[c-1] = wr_data;
        if (c == nk) check("sub_rot", sub_in, {exp_w[c-1][23:0], exp_w[c-1][31:24]});
        if (nk == 8 && c == 12) check("sub_j4", sub_in, exp_w[11]);
      end else begin
        check("tail", {wr_en, busy, done}, {2'b00, c == nw + 1});
      end
      start = repulse && (c == 10 || c == 44);
      rst   = (rst_at > 0 && c == rst_at);
      @(posedge clk);
    end
    check("done_cnt", n_done, (rst_at > 0) ? 0 : 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; key_len = 2'd0; key_in = K128;
    @(posedge clk); #1;
    start = 1'b0;
    check("reset", {wr_en, busy, done, wr_addr, wr_data, sub_in}, '0);
`ifdef AES_KEY_EXPAND_NR_OUT_EN
    check("nr_rst", nr, 4'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("idle_hold", {wr_en, busy, done, sub_in}, '0);
    @(posedge clk);

    run(2'd0, K128, 4, 44, 0, 1'b0);
    check("128_w4", got_w[4], 32'ha0fafe17);
    check("128_w43", got_w[43], 32'hb6630ca6);

    run(2'd1, K192, 6, 52, 0, 1'b0);
    check("192_w6", got_w[6], 32'hfe0c91f7);
    check("192_w51", got_w[51], 32'h01002202);
`ifdef AES_KEY_EXPAND_NR_OUT_EN
    check("nr_192", nr, 4'd12);
`endif

    run(2'd2, K256, 8, 60, 0, 1'b0);
    check("256_w8", got_w[8], 32'h9ba35411);
    check("256_w12", got_w[12], 32'ha8b09c1a);
    check("256_w59", got_w[59], 32'h706c631e);
`ifdef AES_KEY_EXPAND_NR_OUT_EN
    check("nr_256", nr, 4'd14);
`endif

    run(2'd0, K128, 4, 44, 0, 1'b1);
    check("rep_w43", got_w[43], 32'hb6630ca6);

    run(2'd2, K256, 8, 60, 20, 1'b0);
    run(2'd0, K128, 4, 44, 0, 1'b0);
    check("post_rst_w4", got_w[4], 32'ha0fafe17);
    check("post_rst_w43", got_w[43], 32'hb6630ca6);

    run(2'd3, K128, 4, 44, 0, 1'b0);
    check("kl3_w4", got_w[4], 32'ha0fafe17);
    check("kl3_w43", got_w[43], 32'hb6630ca6);
`ifdef AES_KEY_EXPAND_NR_OUT_EN
    check("nr_kl3", nr, 4'd10);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_key_expand_ctrl.md
Name: aes_key_expand_ctrl

Overview:
Sequential AES key-expansion engine. It generates the round-key words w[0..Nw-1] for AES-128, AES-192 and AES-256, one 32-bit word per clock. Each word is written into the KeyExpansion 64x32 register file, whose 64:1 read mux later serves round keys to the cipher datapath. SubWord is an external, existing combinational S-box unit driven through the sub_in/sub_out port pair.

Parameters:
ADDR_W, 6, register-file address width; 64 entries cover Nw max = 60.
DATA_W, 32, word width; fixed at 32 for AES and not otherwise supported.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle request; sampled only in IDLE
key_len  input  2  0=AES-128, 1=AES-192, 2=AES-256, 3=reserved (treated as 0)
key_in  input  256  cipher key, left-aligned: w0=key_in[255:224], w1=key_in[223:192], ...; unused low bits ignored
sub_out  input  32  SubWord(sub_in) from external S-box unit, combinational, same cycle
sub_in  output  32  word presented to the S-box unit
wr_en  output  1  register-file write strobe
wr_addr  output  6  register-file write address = word index i
wr_data  output  32  w[i]
busy  output  1  high while words are being produced
done  output  1  one-cycle pulse after the last write

Behaviour:
- Reset: state IDLE; wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, rcon=0x01, counters=0, window cleared.
- Nk/Nw decode at start: 128 -> 4/44; 192 -> 6/52; 256 -> 8/60. Latched for the whole run.
- FSM states: IDLE, LOAD, EXPAND, FIN.
- IDLE -> LOAD when start=1. Latch key_in and key_len; rcon=0x01; i=0; j=0, where j = i mod Nk, held as a wrap counter with no divider.
- LOAD: one word per cycle, w[i] = key word i. Each word is pushed into an 8-deep window shift register.
  - LOAD -> EXPAND after word Nk-1 is written.
- EXPAND, each cycle:
  - temp = w[i-1].
  - If j==0: sub_in = RotWord(w[i-1]) = {w[23:0], w[31:24]}; temp = sub_out ^ {rcon, 24'h0}. After use, rcon = xtime(rcon) = (rcon<<1) ^ (rcon[7] ? 8'h1B : 8'h00), truncated to 8 bits.
  - Else if Nk==8 and j==4: sub_in = w[i-1]; temp = sub_out.
  - Else: sub_in = w[i-1]; sub_out is ignored.
  - w[i] = w[i-Nk] ^ temp, where w[i-Nk] is read from the window at depth Nk.
  - EXPAND -> FIN after i = Nw-1 is written.
- Outputs are registered: wr_en/wr_addr/wr_data for word i appear together in one cycle. wr_addr increments by 1 per cycle with no gaps.
- Timing: start sampled at edge 0. Word 0 is written in cycle 1; word Nw-1 in cycle Nw. FIN asserts done=1 in cycle Nw+1 with wr_en=0, then returns to IDLE.
- busy is high in cycles 1..Nw and low in FIN and IDLE.
- Total latency from start to done: 45, 53 or 61 cycles for AES-128, -192, -256.
- start while busy or in FIN: ignored; the current run continues unaffected.
- start in the same cycle as rst: rst wins; the block stays in IDLE.
- rst mid-run: next cycle is IDLE with all outputs at reset values. No further writes occur. Register-file contents already written are left as-is, and no done pulse is issued.
- rcon sequence is checked up to 0x36 (AES-128 round 10); the wrap 0x80 -> 0x1B must be exact.
- key_len=3 behaves exactly like key_len=0.
- sub_in is don't-care outside EXPAND but must not be X; drive 0 in IDLE.

Optional Feature:
Macro: AES_KEY_EXPAND_NR_OUT_EN.
- Defined: adds output port nr [3:0], registered at start: 10, 12 or 14 for key_len 0/1(3→0)/2. Reset value 0; held until the next accepted start.
- Undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c -> 44 writes at addr 0..43: w4=a0fafe17, w43=b6630ca6; done in cycle 45.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> 52 writes: w6=fe0c91f7, w51=01002202; done in cycle 53.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> 60 writes: w8=9ba35411, w12=a8b09c1a (j==4 SubWord path), w59=706c631e; done in cycle 61.
- AES-128 run with start re-pulsed at cycles 10 and 44 -> sequence and values identical to scenario 1; exactly one done pulse.
- AES-256 run with rst asserted at cycle 20 -> wr_en=0 and busy=0 from cycle 21; no done. A subsequent AES-128 start then yields correct w0..w43 with rcon restarting at 0x01.
- key_len=3 with the AES-128 key -> output identical to scenario 1. With AES_KEY_EXPAND_NR_OUT_EN defined, nr=10; with key_len=2, nr=14.
